// File: rtl/fifo_read_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_read_scheduler
//  Description : Round-robin, burst-based read scheduler. It drains the read
//                sides of NUM_PORTS FWFT FIFOs into a single registered
//                valid/ready output stream. One port is granted at a time.
//                The grant is held until the burst limit is reached, the
//                FIFO runs empty, or the idle-gap timeout expires.
//  Ports       : clock, reset_n (async, active-low)
//                enable               - allow new grants (sampled in IDLE)
//                fifo_read_data       - per-port read data, port p at
//                                       [p*DATA_WIDTH +: DATA_WIDTH]
//                fifo_read_data_valid - per-port FWFT data valid
//                fifo_empty           - per-port empty flag
//                fifo_read_enable     - per-port pop strobe
//                out_data/out_valid/out_ready - registered output stream
//                out_source           - port that supplied out_data
//                busy                 - high while a grant is held
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_BURST   = 8,
  parameter int GAP_TIMEOUT = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_read_data,
  input  logic [NUM_PORTS-1:0]            fifo_read_data_valid,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  output logic [NUM_PORTS-1:0]            fifo_read_enable,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]    out_source,
  output logic                            busy
);

  localparam int PTR_W   = $clog2(NUM_PORTS);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int GAP_W   = $clog2(GAP_TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [PTR_W-1:0]   LAST_PORT   = PTR_W'(NUM_PORTS - 1);
  localparam logic [BURST_W-1:0] BURST_LAST  = BURST_W'(MAX_BURST - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [0:0]            state_q,       state_d;
  logic [PTR_W-1:0]      grant_q,       grant_d;
  logic [PTR_W-1:0]      last_grant_q,  last_grant_d;
  logic [BURST_W-1:0]    burst_count_q, burst_count_d;
  logic [GAP_W-1:0]      gap_count_q,   gap_count_d;
  logic [DATA_WIDTH-1:0] out_data_q,    out_data_d;
  logic                  out_valid_q,   out_valid_d;
  logic [PTR_W-1:0]      out_source_q,  out_source_d;

  // --------------------------------------------------------------------------
  // Per-port data view
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_data
    assign port_data[p] = fifo_read_data[p*DATA_WIDTH +: DATA_WIDTH];
  end

  // --------------------------------------------------------------------------
  // Handshake with the granted FIFO
  // --------------------------------------------------------------------------
  logic in_burst;
  logic out_free;
  logic granted_valid;
  logic granted_empty;
  logic xfer;

  assign in_burst      = (state_q == ST_BURST);
  assign out_free      = !out_valid_q || out_ready;
  assign granted_valid = fifo_read_data_valid[grant_q];
  assign granted_empty = fifo_empty[grant_q];
  // The FIFO pops on read_enable, so it is only raised alongside valid data
  // and only when the output register can take the word in the same cycle.
  assign xfer          = in_burst && granted_valid && out_free;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_en
    assign fifo_read_enable[p] = xfer && (grant_q == PTR_W'(p));
  end

  // --------------------------------------------------------------------------
  // Round-robin search: first valid port after last_grant, wrapping modulo
  // NUM_PORTS. The last_grant port itself is checked last so it can be
  // re-granted when it is the only one pending.
  // --------------------------------------------------------------------------
  logic             pick_found;
  logic [PTR_W-1:0] pick_port;
  logic [PTR_W-1:0] search_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_port  = '0;
    search_idx = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      search_idx = PTR_W'((int'(last_grant_q) + i) % NUM_PORTS);
      if (!pick_found && fifo_read_data_valid[search_idx]) begin
        pick_found = 1'b1;
        pick_port  = search_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Burst release conditions
  // --------------------------------------------------------------------------
  logic exit_burst_limit;
  logic exit_empty;
  logic exit_gap;
  logic exit_any;

  assign exit_burst_limit = xfer && (burst_count_q == BURST_LAST);
  assign exit_empty       = !granted_valid && granted_empty;
  assign exit_gap         = !granted_valid && (gap_count_q == GAP_LAST);
  assign exit_any         = exit_burst_limit || exit_empty || exit_gap;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    burst_count_d = burst_count_q;
    gap_count_d   = gap_count_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_source_d  = out_source_q;

    // Output register: load on a transfer, otherwise drain on accept.
    if (xfer) begin
      out_data_d   = port_data[grant_q];
      out_valid_d  = 1'b1;
      out_source_d = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && pick_found) begin
          grant_d       = pick_port;
          burst_count_d = '0;
          gap_count_d   = '0;
          state_d       = ST_BURST;
        end
      end

      ST_BURST: begin
        if (xfer) begin
          burst_count_d = burst_count_q + BURST_W'(1);
          gap_count_d   = '0;
        end else if (!granted_valid && !granted_empty) begin
          // Only missing data counts as a gap; a backpressure stall with
          // valid data held leaves gap_count untouched.
          gap_count_d   = gap_count_q + GAP_W'(1);
        end

        if (exit_any) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= LAST_PORT;
      burst_count_q <= '0;
      gap_count_q   <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_source_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      burst_count_q <= burst_count_d;
      gap_count_q   <= gap_count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_source_q  <= out_source_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_source = out_source_q;
  assign busy       = in_burst;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_scheduler
//  Description : Directed self-checking bench for fifo_read_scheduler with
//                four FWFT FIFO models (hold flag emulates a gap in valid
//                data while the FIFO is not empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_scheduler;

  localparam int NP = 4;
  localparam int DW = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [NP*DW-1:0] fifo_read_data;
  logic [NP-1:0]   fifo_read_data_valid;
  logic [NP-1:0]   fifo_empty;
  logic [NP-1:0]   fifo_read_enable;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_source;
  logic            busy;

  fifo_read_scheduler #(
    .NUM_PORTS   (NP),
    .DATA_WIDTH  (DW),
    .MAX_BURST   (8),
    .GAP_TIMEOUT (4)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .enable               (enable),
    .fifo_read_data       (fifo_read_data),
    .fifo_read_data_valid (fifo_read_data_valid),
    .fifo_empty           (fifo_empty),
    .fifo_read_enable     (fifo_read_enable),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_source           (out_source),
    .busy                 (busy)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // FIFO models
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [NP][64];
  logic [5:0]    wr_ptr [NP];
  logic [5:0]    rd_ptr [NP];
  logic [NP-1:0] hold;

  always_comb begin
    fifo_read_data       = '0;
    fifo_read_data_valid = '0;
    fifo_empty           = '0;
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p]             = (rd_ptr[p] == wr_ptr[p]);
      fifo_read_data_valid[p]   = !fifo_empty[p] && !hold[p];
      fifo_read_data[p*DW +: DW] = mem[p][rd_ptr[p]];
    end
  end

  always @(posedge clock) begin
    for (int p = 0; p < NP; p++) begin
      if (fifo_read_enable[p]) rd_ptr[p] <= rd_ptr[p] + 6'd1;
    end
  end

  task automatic push(input int p, input logic [DW-1:0] d);
    mem[p][wr_ptr[p]] = d;
    wr_ptr[p] = wr_ptr[p] + 6'd1;
  endtask

  // --------------------------------------------------------------------------
  // Output log: every word accepted downstream
  // --------------------------------------------------------------------------
  logic [DW-1:0] log_data [256];
  logic [1:0]    log_src  [256];
  logic [7:0]    n_log = 8'd0;

  always @(posedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      log_data[n_log] <= out_data;
      log_src[n_log]  <= out_source;
      n_log           <= n_log + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic reached = 1'b0;
    for (int n = 0; n < 400 && !reached; n++) begin
      @(negedge clock);
      if (!busy && !out_valid && fifo_read_data_valid == '0) reached = 1'b1;
    end
    check(tag, {31'd0, reached}, 32'd1);
  endtask

  // Checks n words logged from index base: all from one port, data ascending.
  task automatic check_run(input string tag, input int base, input int n,
                           input int port, input logic [DW-1:0] first);
    check({tag, "_count"}, 32'(int'(n_log) - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      check({tag, "_word"}, {14'd0, log_src[8'(base + k)], log_data[8'(base + k)]},
            {14'd0, 2'(port), first + DW'(k)});
    end
  endtask

  // Burst table for two ports with 20 words each and MAX_BURST=8
  int burst_len [6] = '{8, 8, 8, 8, 4, 4};
  int burst_src [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    int base;
    int k;
    int cnt [2];
    logic [5:0] rp0;
    logic [5:0] popped;

    reset_n   = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    hold      = '0;
    for (int p = 0; p < NP; p++) begin
      wr_ptr[p] = '0;
    end

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_data",   {16'd0, out_data}, 32'd0);
    check("rst_out_source", {30'd0, out_source}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_rd_en",      {28'd0, fifo_read_enable}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // ---------------- single short burst on port 2 ----------------
    push(2, 16'h000A); push(2, 16'h000B); push(2, 16'h000C);
    @(negedge clock);
    check("t1_busy",  {31'd0, busy}, 32'd1);
    check("t1_rd_en", {28'd0, fifo_read_enable}, 32'h4);
    check("t1_nv",    {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t1_word", {13'd0, out_valid, out_source, out_data},
            {13'd0, 1'b1, 2'd2, 16'h000A + 16'(i)});
    end
    @(negedge clock);
    check("t1_end_busy",  {31'd0, busy}, 32'd0);
    check("t1_end_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- two ports alternating bursts ----------------
    base = int'(n_log);
    for (int i = 0; i < 20; i++) begin
      push(0, 16'h0100 + 16'(i));
      push(1, 16'h0200 + 16'(i));
    end
    wait_idle("t2_idle");
    check("t2_count", 32'(int'(n_log) - base), 32'd40);
    cnt[0] = 0; cnt[1] = 0; k = 0;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < burst_len[b]; j++) begin
        check("t2_word", {14'd0, log_src[8'(base + k)], log_data[8'(base + k)]},
              {14'd0, 2'(burst_src[b]), 16'h0100 * 16'(burst_src[b] + 1) + 16'(cnt[burst_src[b]])});
        cnt[burst_src[b]]++;
        k++;
      end
    end

    // ---------------- backpressure mid-burst ----------------
    base = int'(n_log);
    for (int i = 0; i < 6; i++) push(0, 16'h0300 + 16'(i));
    repeat (4) @(negedge clock);
    check("t3_pre_stall", {16'd0, out_data}, 32'h0302);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_stall_data",  {16'd0, out_data}, 32'h0302);
      check("t3_stall_rd_en", {28'd0, fifo_read_enable}, 32'd0);
      check("t3_stall_busy",  {30'd0, busy, out_valid}, 32'h3);
    end
    out_ready = 1'b1;
    wait_idle("t3_idle");
    check_run("t3", base, 6, 0, 16'h0300);

    // ---------------- gap timeout releases the grant ----------------
    base = int'(n_log);
    for (int i = 0; i < 4; i++) push(1, 16'h0400 + 16'(i));
    repeat (2) @(negedge clock);
    check("t4_first", {16'd0, out_data}, 32'h0400);
    hold[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t4_gap_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clock);
    check("t4_release", {31'd0, busy}, 32'd0);
    hold[1] = 1'b0;
    wait_idle("t4_idle");
    check_run("t4", base, 4, 1, 16'h0400);

    // ---------------- valid returns before the timeout ----------------
    base = int'(n_log);
    for (int i = 0; i < 4; i++) push(1, 16'h0410 + 16'(i));
    repeat (2) @(negedge clock);
    hold[1] = 1'b1;
    repeat (2) @(negedge clock);
    hold[1] = 1'b0;
    @(negedge clock);
    check("t4b_resume", {12'd0, busy, out_valid, 1'b0, out_source, out_data},
          {12'd0, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0411});
    wait_idle("t4b_idle");
    check_run("t4b", base, 4, 1, 16'h0410);

    // ---------------- round-robin order, enable gating ----------------
    base = int'(n_log);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(0, 16'h0500 + 16'(i));
      push(1, 16'h0510 + 16'(i));
      push(3, 16'h0530 + 16'(i));
    end
    repeat (3) @(negedge clock);
    check("t5_hold_busy",  {31'd0, busy}, 32'd0);
    check("t5_hold_rd_en", {28'd0, fifo_read_enable}, 32'd0);
    enable = 1'b1;
    wait_idle("t5_idle");
    check("t5_count", 32'(int'(n_log) - base), 32'd6);
    check("t5_w0", {14'd0, log_src[8'(base + 0)], log_data[8'(base + 0)]}, {14'd0, 2'd3, 16'h0530});
    check("t5_w1", {14'd0, log_src[8'(base + 1)], log_data[8'(base + 1)]}, {14'd0, 2'd3, 16'h0531});
    check("t5_w2", {14'd0, log_src[8'(base + 2)], log_data[8'(base + 2)]}, {14'd0, 2'd0, 16'h0500});
    check("t5_w3", {14'd0, log_src[8'(base + 3)], log_data[8'(base + 3)]}, {14'd0, 2'd0, 16'h0501});
    check("t5_w4", {14'd0, log_src[8'(base + 4)], log_data[8'(base + 4)]}, {14'd0, 2'd1, 16'h0510});
    check("t5_w5", {14'd0, log_src[8'(base + 5)], log_data[8'(base + 5)]}, {14'd0, 2'd1, 16'h0511});

    // ---------------- reset mid-burst ----------------
    rp0 = rd_ptr[2];
    for (int i = 0; i < 8; i++) push(2, 16'h0600 + 16'(i));
    repeat (2) @(negedge clock);
    out_ready = 1'b0;
    @(negedge clock);
    check("t6_pre_rst", {30'd0, busy, out_valid}, 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_busy",  {31'd0, busy}, 32'd0);
    check("t6_rst_rd_en", {28'd0, fifo_read_enable}, 32'd0);
    @(negedge clock);
    popped = rd_ptr[2] - rp0;
    check("t6_popped", {26'd0, popped}, 32'd1);
    push(0, 16'h0700); push(1, 16'h0710); push(3, 16'h0730);
    out_ready = 1'b1;
    reset_n   = 1'b1;
    @(negedge clock);
    check("t6_first_grant", {27'd0, busy, fifo_read_enable}, {27'd0, 1'b1, 4'h1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
